// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared address map, register field positions and region
//                decode for the data-side bus block.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] CAM_STATUS_ADDR = 32'h8000_0000;
    localparam logic [31:0] CAM_DATA_ADDR   = 32'h8000_0004;
    localparam logic [31:0] CAM_CTRL_ADDR   = 32'h8000_0008;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_FRAME_LSB = 16;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CAM_STATUS,
        REG_CAM_DATA,
        REG_CAM_CTRL,
        REG_NONE
    } region_e;

    function automatic region_e decode_region(input logic [31:0] addr);
        region_e r;
        if (!addr[31]) begin
            r = REG_RAM;
        end else begin
            case (addr)
                CAM_STATUS_ADDR: r = REG_CAM_STATUS;
                CAM_DATA_ADDR:   r = REG_CAM_DATA;
                CAM_CTRL_ADDR:   r = REG_CAM_CTRL;
                default:         r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with level count and flush; DEPTH must be
//                a power of two (>= 2) so the pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_level = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w:0]   r_level_q,  w_level_d;
    logic               w_do_push, w_do_pop;

    assign full  = (r_level_q == c_full_level);
    assign empty = (r_level_q == '0);
    assign level = r_level_q;
    assign head  = r_mem_q[r_rd_ptr_q];

    // Flush overrides any push/pop arriving in the same cycle.
    always_comb begin
        w_do_push  = push && !full  && !flush;
        w_do_pop   = pop  && !empty && !flush;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
            if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   w_level_d = r_level_q + (c_ptr_w + 1)'(1);
                2'b01:   w_level_d = r_level_q - (c_ptr_w + 1)'(1);
                default: w_level_d = r_level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/data_bus_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_mmio
//  Description : Data-side bus: word RAM plus memory-mapped camera pixel FIFO
//                with status, data and control registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bus_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int PIXEL_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write_enable,
    input  logic               read_enable,
    input  logic [31:0]        WriteAddress,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    input  logic               cam_valid,
    input  logic [PIXEL_W-1:0] cam_pixel,
    input  logic               cam_frame_start,
    output logic               cam_ready
);

    localparam int c_ram_aw = $clog2(RAM_WORDS);
    localparam int c_lvl_w  = $clog2(FIFO_DEPTH) + 1;

    region_e             w_region;
    logic [c_ram_aw-1:0] w_ram_idx;
    logic [31:0]         r_ram_q [RAM_WORDS];

    logic        r_enable_q,      w_enable_d;
    logic        r_overflow_q,    w_overflow_d;
    logic [15:0] r_frame_count_q, w_frame_count_d;

    logic w_ram_we, w_ctrl_we, w_flush, w_clr_ovf;
    logic w_push, w_pop, w_ovf_set;

    logic [PIXEL_W-1:0] w_head;
    logic [c_lvl_w-1:0] w_level;
    logic               w_full, w_empty;
    logic [31:0]        w_status, w_pixel_word;

    assign w_region  = decode_region(WriteAddress);
    assign w_ram_idx = WriteAddress[c_ram_aw+1:2];

    always_comb begin
        w_ram_we        = write_enable && (w_region == REG_RAM);
        w_ctrl_we       = write_enable && (w_region == REG_CAM_CTRL);
        w_flush         = w_ctrl_we && WriteData[CTRL_FLUSH_BIT];
        w_clr_ovf       = w_ctrl_we && WriteData[CTRL_CLR_OVF_BIT];
        cam_ready       = r_enable_q && !w_full;
        w_push          = r_enable_q && cam_valid && cam_ready;
        w_ovf_set       = r_enable_q && cam_valid && w_full;
        w_pop           = read_enable && (w_region == REG_CAM_DATA) && !w_empty;

        w_enable_d      = w_ctrl_we ? WriteData[CTRL_ENABLE_BIT] : r_enable_q;
        // A drop in the same cycle as a clear must leave the flag set.
        w_overflow_d    = w_ovf_set ? 1'b1 : (w_clr_ovf ? 1'b0 : r_overflow_q);
        w_frame_count_d = (cam_frame_start && r_enable_q) ? r_frame_count_q + 16'd1
                                                          : r_frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable_q      <= 1'b0;
            r_overflow_q    <= 1'b0;
            r_frame_count_q <= 16'd0;
        end else begin
            r_enable_q      <= w_enable_d;
            r_overflow_q    <= w_overflow_d;
            r_frame_count_q <= w_frame_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram_q[w_ram_idx] <= WriteData;
    end

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_flush),
        .wr_data (cam_pixel),
        .head    (w_head),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        w_status                                = '0;
        w_status[STAT_FRAME_LSB +: 16]          = r_frame_count_q;
        w_status[STAT_LEVEL_LSB +: c_lvl_w]     = w_level;
        w_status[STAT_OVF_BIT]                  = r_overflow_q;
        w_status[STAT_FULL_BIT]                 = w_full;
        w_status[STAT_EMPTY_BIT]                = w_empty;

        w_pixel_word = '0;
        if (!w_empty) w_pixel_word[PIXEL_W-1:0] = w_head;

        case (w_region)
            REG_RAM:        ReadData = r_ram_q[w_ram_idx];
            REG_CAM_STATUS: ReadData = w_status;
            REG_CAM_DATA:   ReadData = w_pixel_word;
            REG_CAM_CTRL:   ReadData = {31'd0, r_enable_q};
            default:        ReadData = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_bus_mmio
//  Description : Self-checking bench for data_bus_mmio with a pixel
//                scoreboard and a small reference model of the camera block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_mmio;

    localparam logic [31:0] A_ST = 32'h8000_0000;
    localparam logic [31:0] A_DT = 32'h8000_0004;
    localparam logic [31:0] A_CT = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable, read_enable;
    logic [31:0] WriteAddress, WriteData, ReadData;
    logic        cam_valid, cam_frame_start, cam_ready;
    logic [15:0] cam_pixel;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_q[$];
    bit          m_en, m_ovf;
    logic [15:0] m_fc;
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    data_bus_mmio dut (
        .clk             (clk),
        .reset           (reset),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .WriteAddress    (WriteAddress),
        .WriteData       (WriteData),
        .ReadData        (ReadData),
        .cam_valid       (cam_valid),
        .cam_pixel       (cam_pixel),
        .cam_frame_start (cam_frame_start),
        .cam_ready       (cam_ready)
    );

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[31:16] = m_fc;
        s[15:8]  = 8'(m_q.size());
        s[2]     = m_ovf;
        s[1]     = (m_q.size() == 16);
        s[0]     = (m_q.size() == 0);
        return s;
    endfunction

    function automatic logic [31:0] exp_pixel();
        return (m_q.size() != 0) ? {16'h0, m_q[0]} : 32'h0;
    endfunction

    // Reference model: next state from the inputs currently driven.
    task automatic model_step();
        bit full, ctrl, push, pop;
        full = (m_q.size() == 16);
        ctrl = write_enable && (WriteAddress == A_CT);
        push = m_en && cam_valid && !full;
        pop  = read_enable && (WriteAddress == A_DT) && (m_q.size() != 0);
        if (reset) begin
            m_q.delete();
            m_en = 0; m_ovf = 0; m_fc = 16'h0;
        end else begin
            if (m_en && cam_frame_start) m_fc = m_fc + 16'h1;
            if (ctrl && WriteData[1]) m_q.delete();
            else begin
                if (pop)  void'(m_q.pop_front());
                if (push) m_q.push_back(cam_pixel);
            end
            if (m_en && cam_valid && full) m_ovf = 1;
            else if (ctrl && WriteData[2]) m_ovf = 0;
            if (ctrl) m_en = WriteData[0];
        end
    endtask

    task automatic set_in(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic cv,
                          input logic [15:0] px, input logic fs);
        @(negedge clk);
        write_enable = we; read_enable = re; WriteAddress = a; WriteData = d;
        cam_valid = cv; cam_pixel = px; cam_frame_start = fs;
        #1;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, A_ST, 0, 0, 0, 0); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0); advance();
        reset = 1'b0;
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL reset_status got %h exp %h", ReadData, 32'h1);
        end
        checks++;
        if (cam_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", cam_ready);
        end
        set_in(0, 0, A_CT, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl got %h exp 0", ReadData);
        end
        advance();
    endtask

    task automatic test_ram();
        set_in(1, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0); advance();
        set_in(0, 0, 32'h10, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_read got %h exp %h", ReadData, 32'hDEAD_BEEF);
        end
        set_in(0, 0, 32'h110, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_alias got %h exp %h", ReadData, 32'hDEAD_BEEF);
        end
        set_in(1, 0, 32'h13, 32'h1234_5678, 0, 0, 0);
        checks++;
        if (ReadData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_old_on_write got %h exp %h", ReadData, 32'hDEAD_BEEF);
        end
        advance();
        set_in(1, 0, 32'h8000_0010, 32'hAAAA_5555, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h exp 0", ReadData);
        end
        advance();
        set_in(0, 0, 32'h10, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_after_unmapped got %h exp %h", ReadData, 32'h1234_5678);
        end
        advance();
    endtask

    task automatic test_stream();
        set_in(1, 0, A_CT, 32'h1, 0, 0, 0); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (cam_ready !== 1'b1) begin
            errors++; $display("FAIL stream_ready got %b exp 1", cam_ready);
        end
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 0, A_ST, 0, 1, 16'(i), 0); advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0300 || ReadData !== exp_status()) begin
            errors++; $display("FAIL stream_status got %h exp %h", ReadData, 32'h300);
        end
        for (int i = 1; i <= 3; i++) begin
            set_in(0, 1, A_DT, 0, 0, 0, 0);
            exp_v = exp_pixel();
            checks++;
            if (ReadData !== exp_v || ReadData !== 32'(i)) begin
                errors++; $display("FAIL stream_pop%0d got %h exp %h", i, ReadData, exp_v);
            end
            advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL stream_drained got %h exp %h", ReadData, 32'h1);
        end
        advance();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            set_in(0, 0, A_ST, 0, 1, 16'h0100 + 16'(i), 0);
            checks++;
            if (cam_ready !== 1'(i < 16)) begin
                errors++; $display("FAIL ovf_ready%0d got %b exp %b", i, cam_ready, (i < 16));
            end
            advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_1006 || ReadData !== exp_status()) begin
            errors++; $display("FAIL ovf_status got %h exp %h", ReadData, 32'h1006);
        end
        advance();
        set_in(1, 0, A_CT, 32'h5, 0, 0, 0); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_1002) begin
            errors++; $display("FAIL ovf_cleared got %h exp %h", ReadData, 32'h1002);
        end
        set_in(0, 0, A_CT, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h1) begin
            errors++; $display("FAIL ovf_enable_kept got %h exp 1", ReadData);
        end
        for (int i = 0; i < 16; i++) begin
            set_in(0, 1, A_DT, 0, 0, 0, 0);
            exp_v = exp_pixel();
            checks++;
            if (ReadData !== exp_v || ReadData !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, ReadData, exp_v);
            end
            advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL ovf_lost_pixel got %h exp %h", ReadData, 32'h1);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, A_ST, 0, 1, 16'h0200 + 16'(i), 0); advance();
        end
        set_in(0, 1, A_DT, 0, 1, 16'h02FF, 0);
        exp_v = exp_pixel();
        checks++;
        if (ReadData !== exp_v || ReadData !== 32'h200) begin
            errors++; $display("FAIL b2b_old_head got %h exp %h", ReadData, exp_v);
        end
        advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0500) begin
            errors++; $display("FAIL b2b_level got %h exp %h", ReadData, 32'h500);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, A_DT, 0, 0, 0, 0);
            exp_v = exp_pixel();
            checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, ReadData, exp_v);
            end
            advance();
        end
        set_in(0, 1, A_DT, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0) begin
            errors++; $display("FAIL empty_read got %h exp 0", ReadData);
        end
        advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL empty_read_level got %h exp %h", ReadData, 32'h1);
        end
        advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, A_ST, 0, 1, 16'h0300 + 16'(i), 0); advance();
        end
        set_in(1, 0, A_CT, 32'h3, 1, 16'h03AA, 0); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001 || ReadData !== exp_status()) begin
            errors++; $display("FAIL flush_status got %h exp %h", ReadData, 32'h1);
        end
        checks++;
        if (cam_ready !== 1'b1) begin
            errors++; $display("FAIL flush_enable got %b exp 1", cam_ready);
        end
        advance();
    endtask

    task automatic test_frame_count();
        for (int n = 0; n < 70000 && m_fc != 16'hFFFF; n++) begin
            set_in(0, 0, A_ST, 0, 0, 0, 1); advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'hFFFF_0001) begin
            errors++; $display("FAIL frame_max got %h exp %h", ReadData, 32'hFFFF_0001);
        end
        set_in(0, 0, A_ST, 0, 0, 0, 1); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL frame_wrap got %h exp %h", ReadData, 32'h1);
        end
        set_in(1, 0, A_CT, 32'h0, 0, 0, 0); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 1); advance();
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001 || ReadData !== exp_status()) begin
            errors++; $display("FAIL frame_disabled got %h exp %h", ReadData, 32'h1);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 32'h20, 32'hCAFE_F00D, 0, 0, 0); advance();
        set_in(1, 0, A_CT, 32'h1, 0, 0, 0); advance();
        for (int i = 0; i < 17; i++) begin
            set_in(0, 0, A_ST, 0, 1, 16'h0400 + 16'(i), 0); advance();
        end
        for (int i = 0; i < 9; i++) begin
            set_in(0, 1, A_DT, 0, 0, 0, 0);
            exp_v = exp_pixel();
            checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL mid_drain%0d got %h exp %h", i, ReadData, exp_v);
            end
            advance();
        end
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0704) begin
            errors++; $display("FAIL mid_pre_reset got %h exp %h", ReadData, 32'h704);
        end
        reset = 1'b1;
        set_in(0, 0, A_ST, 0, 1, 16'h0555, 1); advance();
        reset = 1'b0;
        set_in(0, 0, A_ST, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'h0000_0001) begin
            errors++; $display("FAIL mid_reset_status got %h exp %h", ReadData, 32'h1);
        end
        checks++;
        if (cam_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ready got %b exp 0", cam_ready);
        end
        set_in(0, 0, 32'h20, 0, 0, 0, 0);
        checks++;
        if (ReadData !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL mid_reset_ram got %h exp %h", ReadData, 32'hCAFE_F00D);
        end
        advance();
    endtask

    initial begin
        reset = 1'b1; write_enable = 0; read_enable = 0; WriteAddress = '0;
        WriteData = '0; cam_valid = 0; cam_pixel = '0; cam_frame_start = 0;
        m_en = 0; m_ovf = 0; m_fc = 16'h0;
        test_reset();
        test_ram();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_frame_count();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
